// File: rtl/seg_line_reader.sv
// Seven-segment line reader: debounces the segment pattern, decodes the eight legal glyphs
// to a 3-bit code and hands it over through a valid/ready holding register.
module seg_line_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic SEGA,
  input  logic SEGB,
  input  logic SEGC,
  input  logic SEGD,
  input  logic SEGE,
  input  logic SEGF,
  input  logic SEGG,
  input  logic out_ready,
  output logic A,
  output logic B,
  output logic C,
  output logic out_valid,
  output logic err,
  output logic overrun
);

  localparam logic StSettle = 1'b0;
  localparam logic StLocked = 1'b1;
  localparam logic [3:0] Stable = 4'(STABLE_CYCLES);

  logic [6:0] cap_q, prev_q, last_q;
  logic       primed_q, none_q;
  logic [3:0] cnt_q, cnt_d;
  logic       state_q, state_d;
  logic [2:0] code_q;
  logic       valid_q, err_q, ovr_q;

  logic       changed, accept, legal, new_pat, load;
  logic [2:0] dec_code;

  always_comb begin
    legal    = 1'b1;
    dec_code = 3'd0;
    unique case (cap_q)
      7'h00:   dec_code = 3'd0;
      7'h30:   dec_code = 3'd1;
      7'h6D:   dec_code = 3'd2;
      7'h79:   dec_code = 3'd3;
      7'h33:   dec_code = 3'd4;
      7'h5B:   dec_code = 3'd5;
      7'h5F:   dec_code = 3'd6;
      7'h70:   dec_code = 3'd7;
      default: legal    = 1'b0;
    endcase
  end

  // The first edge after reset only fills cap_q; its reset value is not a real capture.
  always_comb begin
    changed = (cap_q != prev_q);
    cnt_d   = cnt_q;
    state_d = state_q;
    accept  = 1'b0;
    if (!primed_q) begin
      cnt_d = 4'd0;
    end else if (state_q == StSettle) begin
      if (changed || cnt_q == 4'd0) begin
        cnt_d = 4'd1;
      end else if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (cnt_d == Stable) begin
        accept  = 1'b1;
        state_d = StLocked;
      end
    end else if (changed) begin
      state_d = StSettle;
      cnt_d   = 4'd1;
    end
  end

  assign new_pat = accept && (none_q || cap_q != last_q);
  assign load    = new_pat && legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q    <= 7'h00;
      prev_q   <= 7'h00;
      last_q   <= 7'h00;
      primed_q <= 1'b0;
      none_q   <= 1'b1;
      cnt_q    <= 4'd0;
      state_q  <= StSettle;
      code_q   <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cap_q    <= {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG};
      prev_q   <= cap_q;
      primed_q <= 1'b1;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      err_q    <= new_pat && !legal;
      if (new_pat) begin
        last_q <= cap_q;
        none_q <= 1'b0;
      end
      if (load) begin
        code_q  <= dec_code;
        valid_q <= 1'b1;
        if (valid_q && !out_ready) ovr_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign {A, B, C} = code_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg_line_reader.sv
// Bench for seg_line_reader: directed scenarios plus random bursts, checked each edge
// against a run-length model of the applied segment stream.
module tb_seg_line_reader;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, out_ready;
  logic [6:0] seg;
  logic       A, B, C, out_valid, err, overrun;

  always #5 clk = ~clk;

  seg_line_reader #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .reset(reset),
    .SEGA(seg[6]), .SEGB(seg[5]), .SEGC(seg[4]), .SEGD(seg[3]),
    .SEGE(seg[2]), .SEGF(seg[1]), .SEGG(seg[0]),
    .out_ready(out_ready),
    .A(A), .B(B), .C(C), .out_valid(out_valid), .err(err), .overrun(overrun)
  );

  logic [6:0] pat_tab [8] = '{7'h00, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

  // Model: run = edges since reset on which run_val was applied consecutively.
  int         run;
  logic [6:0] run_val;
  logic [6:0] m_last;
  bit         m_none;
  logic [2:0] m_code;
  bit         m_valid, m_err, m_ovr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [6:0] p, input logic rdy, input logic rst);
    bit acc, legal;
    logic [2:0] code;
    seg = p;
    out_ready = rdy;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      run = 0; run_val = 7'h00; m_none = 1; m_last = 7'h00;
      m_code = 3'd0; m_valid = 0; m_err = 0; m_ovr = 0;
    end else begin
      acc = (run == N) && (m_none || run_val != m_last);
      legal = 0;
      code = 3'd0;
      for (int k = 0; k < 8; k++)
        if (pat_tab[k] == run_val) begin legal = 1; code = 3'(k); end
      m_err = acc && !legal;
      if (acc) begin m_last = run_val; m_none = 0; end
      if (acc && legal) begin
        if (m_valid && !rdy) m_ovr = 1;
        m_code = code;
        m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      if (run > 0 && p == run_val) run++;
      else begin run = 1; run_val = p; end
    end
    #1;
    chk("code", {4'd0, A, B, C}, {4'd0, m_code});
    chk("out_valid", {6'd0, out_valid}, {6'd0, m_valid});
    chk("err", {6'd0, err}, {6'd0, m_err});
    chk("overrun", {6'd0, overrun}, {6'd0, m_ovr});
  endtask

  task automatic hold(input logic [6:0] p, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(p, rdy, 1'b0);
  endtask

  initial begin
    run = 0; run_val = 7'h00; m_none = 1; m_last = 7'h00;
    m_code = 3'd0; m_valid = 0; m_err = 0; m_ovr = 0;
    seg = 7'h00; out_ready = 1'b0; reset = 1'b1;

    // Reset, then 0x6D accepted on edge 5 and taken on edge 6
    step(7'h6D, 1'b1, 1'b1);
    step(7'h6D, 1'b1, 1'b1);
    hold(7'h6D, 1'b1, 6);
    // Short glitch to 0x33 then back to 0x6D: nothing new
    hold(7'h33, 1'b1, 3);
    hold(7'h6D, 1'b1, 8);
    // Illegal 0x7F: single err pulse
    hold(7'h7F, 1'b1, 9);
    // Overrun: 0x30 then 0x70 with no consumer
    step(7'h00, 1'b0, 1'b1);
    hold(7'h30, 1'b0, 6);
    hold(7'h70, 1'b0, 6);
    hold(7'h70, 1'b1, 1);
    hold(7'h70, 1'b0, 3);
    // 0x79 transferred, one-edge 0x00 blip, 0x79 again
    hold(7'h79, 1'b1, 7);
    hold(7'h00, 1'b1, 1);
    hold(7'h79, 1'b1, 7);
    // Reset mid-settle with 0x5B held
    hold(7'h5B, 1'b1, 2);
    step(7'h5B, 1'b1, 1'b1);
    hold(7'h5B, 1'b1, N + 3);
    // 0x00 is reported as new right after reset
    step(7'h00, 1'b0, 1'b1);
    hold(7'h00, 1'b0, N + 2);

    for (int b = 0; b < 120; b++) begin
      logic [6:0] p;
      int len;
      if ($urandom_range(0, 2) == 0) p = 7'($urandom);
      else p = pat_tab[$urandom_range(0, 7)];
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 25) == 0) step(p, 1'b0, 1'b1);
      for (int i = 0; i < len; i++) step(p, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_line_reader.md
SEG_LINE_READER -- requirements
Module: seg_line_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..15: number of consecutive sampling edges a segment pattern must be captured before it is accepted.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports SEGA..SEGG  input  1 each  active-high segment lines; pattern written {SEGA..SEGG}, SEGA = MSB.
REQ-005 SHALL have port out_ready  input  1  consumer accepts the held code on an edge where out_valid=1.
REQ-006 SHALL have ports A, B, C  output  1 each  decoded 3-bit code {A,B,C}, A = MSB.
REQ-007 SHALL have port out_valid  output  1  {A,B,C} holds an untransferred code.
REQ-008 SHALL have port err  output  1  one-cycle pulse: an illegal pattern was accepted.
REQ-009 SHALL have port overrun  output  1  sticky: an untransferred code was overwritten.

Function
REQ-010 SHALL treat exactly 8 patterns as legal: 0x00->000, 0x30->001, 0x6D->010, 0x79->011, 0x33->100, 0x5B->101, 0x5F->110, 0x70->111; all others are illegal.
REQ-011 SHALL capture SEGA..SEGG into an input register every edge; all filtering SHALL use the registered value only.
REQ-012 SHALL implement FSM SETTLE/LOCKED plus a saturating run counter (4 bits).
- SETTLE: counter counts consecutive edges on which the captured pattern equals the previous capture.
- Counter reaching STABLE_CYCLES moves FSM to LOCKED and fires one accept event.
- LOCKED: any change in the captured pattern returns FSM to SETTLE with counter = 1; no event fires.
REQ-013 SHALL fire the accept event on the edge after the pattern has been captured on STABLE_CYCLES consecutive edges (N=4: captured edges 1-4, outputs update edge 5); patterns held for fewer edges SHALL be ignored.
REQ-014 SHALL keep a last-accepted register plus a flag "none" (set by reset); an accept event whose pattern equals the last-accepted pattern SHALL produce no output.
REQ-015 SHALL, on an accept event of a new legal pattern, load {A,B,C} with its code, set out_valid=1, and update last-accepted, all on the same edge.
REQ-016 SHALL, on an accept event of a new illegal pattern, pulse err for exactly one cycle and update last-accepted; {A,B,C} and out_valid SHALL be unchanged.
REQ-017 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1, unless a new legal code loads on that edge.
- In that case the new code loads, out_valid stays 1, and overrun is not set.
REQ-018 SHALL, when a new legal code loads while out_valid=1 and out_ready=0, overwrite {A,B,C} and set overrun=1 until reset.
REQ-019 SHALL ignore out_ready while out_valid=0.

Reset
REQ-020 SHALL, on any edge with reset=1, force A,B,C,out_valid,err,overrun = 0, FSM = SETTLE, counter = 0, input register = 0x00, last-accepted flag = "none", regardless of FSM state.
REQ-021 SHALL, after reset, report the first accepted pattern as new, including 0x00 (code 000).

Verification
REQ-022 SHALL cover: reset; hold 0x6D with out_ready=1 -> edge 5 {A,B,C}=010, out_valid=1; edge 6 out_valid=0.
REQ-023 SHALL cover: 0x6D locked; 0x33 held 3 edges, then 0x6D -> no out_valid, no err, {A,B,C} stays 010.
REQ-024 SHALL cover: 0x7F held 4 edges -> err=1 for exactly one cycle on edge 5; {A,B,C} and out_valid unchanged; continued holding gives no further err.
REQ-025 SHALL cover: out_ready=0; accept 0x30, then accept 0x70 -> {A,B,C}=111, out_valid=1, overrun=1; out_ready=1 for one edge -> out_valid=0, overrun stays 1.
REQ-026 SHALL cover: 0x79 locked and transferred; 0x00 for 1 edge, then 0x79 again -> no new event.
REQ-027 SHALL cover: reset pulsed mid-SETTLE with 0x5B applied and held -> all outputs 0; after release, code 101 emitted STABLE_CYCLES+1 edges later.
